sign_extend_unit: RTL and testbench
===================================

// Module: sign_extend_unit
// PURPOSE
//  Registered immediate-extension unit for the 16-bit processor datapath.
//  - Widens the 5-bit instruction immediate field to the 16-bit datapath width
//    by sign extension (default) or zero extension.
//  - Sits between instruction decode and the ALU B-operand mux.
//  - One-cycle pipelined result with a valid flag.
// PARAMETERS
//  IN_W   5   width of immediate field d_in (must be >= 2, < OUT_W)
//  OUT_W  16  width of extended result d_out
// PORTS
//  Clock and reset:
//   clk        input   1      rising-edge clock
//   rst        input   1      reset: synchronous, active-high
//  Inputs:
//   in_valid   input   1      d_in/zext qualify this cycle
//   zext       input   1      0 = sign-extend, 1 = zero-extend
//   d_in       input   IN_W   immediate field to extend
//  Outputs:
//   out_valid  output  1      d_out holds a new result
//   d_out      output  OUT_W  extended immediate, registered
// BEHAVIOUR
//  Reset:
//   - rst high at a rising clk edge forces d_out=0 and out_valid=0.
//   - Reset has priority over in_valid on the same edge.
//   - Reset asserted mid-stream drops any in-flight result; no stale output.
//  Capture (rising clk, rst low, in_valid high):
//   - zext=0: d_out <= {(OUT_W-IN_W){d_in[IN_W-1]}, d_in}.
//   - zext=1: d_out <= {(OUT_W-IN_W){1'b0}, d_in}.
//   - out_valid <= 1.
//  Hold (rising clk, rst low, in_valid low):
//   - d_out keeps its last value.
//   - out_valid <= 0.
//  Timing and width:
//   - Latency exactly 1 cycle.
//   - Back-to-back inputs accepted every cycle; no stall, no backpressure.
//   - Low IN_W bits of d_out always equal the captured d_in.
//   - Upper bits are all-equal: replicated MSB (zext=0) or all zero (zext=1).
//   - Inputs X/unknown while in_valid=0 must not affect d_out.
//   - No combinational path from any input to any output.
// TESTING
//  - rst=1 for 2 cycles -> d_out=16'h0000, out_valid=0.
//  - d_in=5'b01010, zext=0, in_valid=1 -> next cycle d_out=16'h000A, out_valid=1.
//  - d_in=5'b10101, zext=0 -> d_out=16'hFFF5.
//  - d_in=5'b10101, zext=1 -> d_out=16'h0015.
//  - Boundaries, zext=0, back-to-back: d_in=10000,01111,11111,00000
//    -> d_out=FFF0, 000F, FFFF, 0000 on consecutive cycles, out_valid=1 each.
//  - Hold and reset priority:
//    - in_valid=0 after a result -> d_out held, out_valid=0.
//    - rst=1 with in_valid=1, d_in=10000 -> d_out=0000, out_valid=0.

Source files
------------

// File: rtl/sign_extend_unit.sv
// sign_extend_unit: registered immediate widening for the 16-bit datapath.
// Takes the IN_W-bit instruction immediate and produces an OUT_W-bit operand,
// sign- or zero-extended, one cycle later with a valid flag. IN_W must be at
// least 2 and strictly less than OUT_W.
module sign_extend_unit #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             zext,
  input  logic [IN_W-1:0]  d_in,
  output logic             out_valid,
  output logic [OUT_W-1:0] d_out
);

  localparam int STAGES = 1;
  localparam int EXT_W  = OUT_W - IN_W;

  // Valid travels alongside the data: stage 0 is the incoming qualifier.
  logic [STAGES:0]  vld_pipe;
  logic             ext_bit;
  logic [OUT_W-1:0] ext_val;

  // The fill bit is the immediate MSB for signed operands, zero otherwise.
  always_comb begin
    vld_pipe[0] = in_valid;
    ext_bit     = d_in[IN_W-1] & ~zext;
    ext_val     = {{EXT_W{ext_bit}}, d_in};
  end

  // Valid shifts every cycle; reset clears it so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Data only loads on a qualified input, so idle-cycle junk never reaches d_out.
  always_ff @(posedge clk) begin
    if (rst)           d_out <= '0;
    else if (in_valid) d_out <= ext_val;
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sign_extend_unit.sv
// Bench for sign_extend_unit: expected results are queued when an input is
// driven and popped when the matching output appears one cycle later.
module tb_sign_extend_unit;

  localparam int IN_W  = 5;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             zext;
  logic [IN_W-1:0]  d_in;
  logic             out_valid;
  logic [OUT_W-1:0] d_out;

  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] last_out;

  sign_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .zext(zext),
    .d_in(d_in), .out_valid(out_valid), .d_out(d_out)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic widening of a signed value, or plain unsigned widening.
  function automatic logic [OUT_W-1:0] ext_model(input logic [IN_W-1:0] d, input logic z);
    logic signed [IN_W-1:0]  s;
    logic signed [OUT_W-1:0] w;
    s = d;
    w = OUT_W'(s);
    return z ? {{(OUT_W-IN_W){1'b0}}, d} : w;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; zext = 1'b0; d_in = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (d_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_d_out: got %h want %h", d_out, 16'h0000);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    rst = 1'b0;
    last_out = 16'h0000;
  endtask

  // Back-to-back stream from a table of {zext, d_in, expected}.
  task automatic test_back_to_back(input string name, input int n,
                                   input logic [IN_W-1:0] dv[8], input logic zv[8],
                                   input logic [OUT_W-1:0] ev[8]);
    logic [OUT_W-1:0] e;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL %s_valid[%0d]: got %b want 1", name, i-1, out_valid);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (d_out !== e) begin
          n_err++; $display("FAIL %s_data[%0d]: got %h want %h", name, i-1, d_out, e);
        end
        last_out = e;
      end
      if (i < n) begin
        in_valid = 1'b1; d_in = dv[i]; zext = zv[i];
        exp_q.push_back(ev[i]);
      end else begin
        in_valid = 1'b0; d_in = 'x; zext = 1'bx;
      end
    end
  endtask

  // Idle cycles with unknown inputs: output must hold, valid must drop.
  task automatic test_hold;
    in_valid = 1'b0; d_in = 'x; zext = 1'bx;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid);
      end
      n_vec++;
      if (d_out !== last_out) begin
        n_err++; $display("FAIL hold_data[%0d]: got %h want %h", i, d_out, last_out);
      end
    end
  endtask

  // A result goes in, then reset arrives alongside another valid input.
  task automatic test_reset_priority;
    @(negedge clk);
    in_valid = 1'b1; d_in = 5'b01111; zext = 1'b0;
    @(negedge clk);
    n_vec++;
    if (d_out !== 16'h000F || out_valid !== 1'b1) begin
      n_err++; $display("FAIL rstpri_pre: got %h/%b want 000f/1", d_out, out_valid);
    end
    rst = 1'b1; in_valid = 1'b1; d_in = 5'b10000; zext = 1'b0;
    @(negedge clk);
    n_vec++;
    if (d_out !== 16'h0000) begin
      n_err++; $display("FAIL rstpri_data: got %h want 0000", d_out);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstpri_valid: got %b want 0", out_valid);
    end
    rst = 1'b0; in_valid = 1'b0; d_in = 'x; zext = 1'bx;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || d_out !== 16'h0000) begin
      n_err++; $display("FAIL rstpri_after: got %h/%b want 0000/0", d_out, out_valid);
    end
    last_out = 16'h0000;
  endtask

  // Random inputs with random idle gaps, checked against the reference model.
  task automatic test_random(input int n);
    logic pend = 1'b0;
    logic [OUT_W-1:0] e;
    logic [IN_W-1:0] d;
    logic z;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_vec++;
      if (pend) begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || d_out !== e) begin
          n_err++; $display("FAIL rand[%0d]: got %h/%b want %h/1", i, d_out, out_valid, e);
        end
        last_out = e;
      end else begin
        if (out_valid !== 1'b0 || d_out !== last_out) begin
          n_err++; $display("FAIL rand_idle[%0d]: got %h/%b want %h/0", i, d_out, out_valid, last_out);
        end
      end
      pend = (i < n) && ($urandom_range(0, 3) != 0);
      if (pend) begin
        d = IN_W'($urandom); z = 1'($urandom);
        in_valid = 1'b1; d_in = d; zext = z;
        exp_q.push_back(ext_model(d, z));
      end else begin
        in_valid = 1'b0; d_in = 'x; zext = 1'bx;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0]  dv[8];
    logic             zv[8];
    logic [OUT_W-1:0] ev[8];
    test_reset();

    dv[0] = 5'b01010; zv[0] = 1'b0; ev[0] = 16'h000A;
    test_back_to_back("basic", 1, dv, zv, ev);

    dv[0] = 5'b10101; zv[0] = 1'b0; ev[0] = 16'hFFF5;
    dv[1] = 5'b10101; zv[1] = 1'b1; ev[1] = 16'h0015;
    test_back_to_back("zext", 2, dv, zv, ev);

    dv[0] = 5'b10000; zv[0] = 1'b0; ev[0] = 16'hFFF0;
    dv[1] = 5'b01111; zv[1] = 1'b0; ev[1] = 16'h000F;
    dv[2] = 5'b11111; zv[2] = 1'b0; ev[2] = 16'hFFFF;
    dv[3] = 5'b00000; zv[3] = 1'b0; ev[3] = 16'h0000;
    dv[4] = 5'b11111; zv[4] = 1'b1; ev[4] = 16'h001F;
    test_back_to_back("bound", 5, dv, zv, ev);

    test_hold();
    test_reset_priority();
    test_random(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
